// File: rtl/wr_pps_trigger_sched_pkg.sv
// Shared types for the WR PPS trigger scheduler: FSM states, error codes and
// the TAI-second lateness test used when the scheduler sees a PPS edge.
package wr_sched_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_SEC, WAIT_CYC, FIRE} sched_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE   = 2'd0;
    localparam err_code_t ERR_BADCYC = 2'd1;
    localparam err_code_t ERR_NOLOCK = 2'd2;
    localparam err_code_t ERR_LATE   = 2'd3;

    // Late when the current second is 1..511 seconds past the target (mod 1024).
    function automatic logic sec_is_late(input logic [9:0] tai, input logic [9:0] tsec);
        logic [9:0] diff;
        diff = tai - tsec;
        return (diff != 10'd0) && !diff[9];
    endfunction

endpackage

// File: rtl/wr_pps_trigger_sched_if.sv
// Software-facing arm/abort and status bundle of the PPS trigger scheduler.
interface wr_pps_trigger_sched_if;
    import wr_sched_pkg::*;

    logic        arm_i;
    logic        disarm_i;
    logic [9:0]  target_sec_i;
    logic [31:0] target_cyc_i;
    logic        trig_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    err_code_t   err_code_o;

    modport master (
        output arm_i, disarm_i, target_sec_i, target_cyc_i,
        input  trig_o, busy_o, done_o, err_o, err_code_o
    );

    modport slave (
        input  arm_i, disarm_i, target_sec_i, target_cyc_i,
        output trig_o, busy_o, done_o, err_o, err_code_o
    );

endinterface

// File: rtl/wr_pps_trigger_sched_monitor.sv
// PPS health monitor: edge detect, phase counter within the second, period
// measurement and the pps_ok lock indication.
import wr_sched_pkg::*;

module wr_pps_monitor #(
    parameter int unsigned G_CLK_PER_SEC = 62500000,
    parameter int unsigned G_TOL         = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        pps_i,
    input  logic        link_up_i,
    output logic        pps_edge_o,
    output logic [31:0] phase_o,
    output logic        pps_ok_o,
    output logic [31:0] pps_period_o
);

    localparam logic [31:0] PERIOD_LO = 32'(G_CLK_PER_SEC - G_TOL);
    localparam logic [31:0] PERIOD_HI = 32'(G_CLK_PER_SEC + G_TOL);

    logic        pps_dly_q;
    logic [31:0] phase_q;
    logic [31:0] phase_d;
    logic [31:0] period_q;
    logic        ok_q;
    logic        seen_q;
    logic        prev_good_q;
    logic        in_range;

    assign pps_edge_o = pps_i & ~pps_dly_q;
    assign in_range   = (phase_q >= PERIOD_LO) && (phase_q <= PERIOD_HI);
    assign phase_d    = (phase_q == 32'hFFFF_FFFF) ? phase_q : phase_q + 32'd1;

    // The first edge after reset only starts the measurement; lock needs two good periods.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            pps_dly_q   <= 1'b0;
            phase_q     <= 32'd0;
            period_q    <= 32'd0;
            ok_q        <= 1'b0;
            seen_q      <= 1'b0;
            prev_good_q <= 1'b0;
        end else begin
            pps_dly_q <= pps_i;
            if (pps_edge_o) begin
                phase_q     <= 32'd1;
                period_q    <= phase_q;
                seen_q      <= 1'b1;
                prev_good_q <= seen_q & in_range;
                if (!in_range) begin
                    ok_q <= 1'b0;
                end else if (seen_q && prev_good_q) begin
                    ok_q <= 1'b1;
                end
            end else begin
                phase_q <= phase_d;
                if (phase_q > PERIOD_HI) begin
                    ok_q <= 1'b0;
                end
            end
            if (!link_up_i) begin
                ok_q <= 1'b0;
            end
        end
    end

    assign phase_o      = phase_q;
    assign pps_ok_o     = ok_q;
    assign pps_period_o = period_q;

endmodule

// File: rtl/wr_pps_trigger_sched.sv
// Timed trigger scheduler on the White Rabbit time base: waits for an armed
// {TAI second, cycle} target and fires a fixed-width pulse on trig_o.
import wr_sched_pkg::*;

module wr_pps_trigger_sched #(
    parameter int unsigned G_CLK_PER_SEC = 62500000,
    parameter int unsigned G_TOL         = 16,
    parameter int unsigned G_PULSE_LEN   = 4
) (
    input  logic                         clk_sys_i,
    input  logic                         rst_i,
    input  logic                         pps_i,
    input  logic [9:0]                   tm_tai_i,
    input  logic                         link_up_i,
    wr_pps_trigger_sched_if.slave        bus,
    output logic                         pps_ok_o,
    output logic [31:0]                  pps_period_o
);

    localparam int unsigned CNT_W     = $clog2(G_PULSE_LEN + 1);
    localparam logic [31:0] CYC_LIMIT = 32'(G_CLK_PER_SEC);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(G_PULSE_LEN);

    logic         pps_edge;
    logic [31:0]  phase;
    sched_state_t state_q;
    logic [9:0]   tsec_q;
    logic [31:0]  tcyc_q;
    logic [CNT_W-1:0] cnt_q;
    logic         trig_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    err_code_t    code_q;

    wr_pps_monitor #(
        .G_CLK_PER_SEC (G_CLK_PER_SEC),
        .G_TOL         (G_TOL)
    ) u_monitor (
        .clk_sys_i    (clk_sys_i),
        .rst_i        (rst_i),
        .pps_i        (pps_i),
        .link_up_i    (link_up_i),
        .pps_edge_o   (pps_edge),
        .phase_o      (phase),
        .pps_ok_o     (pps_ok_o),
        .pps_period_o (pps_period_o)
    );

    // Entering FIRE raises trig_q at once, so the pulse starts one cycle after the target phase.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tsec_q  <= 10'd0;
            tcyc_q  <= 32'd0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else if (bus.disarm_i) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arm_i) begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        code_q <= ERR_NONE;
                        if (bus.target_cyc_i >= CYC_LIMIT) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_BADCYC;
                        end else if (!pps_ok_o) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_NOLOCK;
                        end else begin
                            tsec_q  <= bus.target_sec_i;
                            tcyc_q  <= bus.target_cyc_i;
                            busy_q  <= 1'b1;
                            state_q <= WAIT_SEC;
                        end
                    end
                end
                WAIT_SEC: begin
                    if (!pps_ok_o || (pps_edge && sec_is_late(tm_tai_i, tsec_q))) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_LATE;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pps_edge && (tm_tai_i == tsec_q)) begin
                        if (tcyc_q == 32'd0) begin
                            trig_q  <= 1'b1;
                            cnt_q   <= CNT_W'(1);
                            state_q <= FIRE;
                        end else begin
                            state_q <= WAIT_CYC;
                        end
                    end
                end
                WAIT_CYC: begin
                    if (!pps_ok_o || pps_edge) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_LATE;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (phase == tcyc_q) begin
                        trig_q  <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                        state_q <= FIRE;
                    end
                end
                FIRE: begin
                    if (cnt_q == PULSE_LAST) begin
                        trig_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.trig_o     = trig_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = code_q;

endmodule

// File: tb/tb_wr_pps_trigger_sched.sv
// Directed + randomized bench for wr_pps_trigger_sched: a PPS/TAI generator and
// an arithmetic model of when each armed target must fire or fail.
module tb_wr_pps_trigger_sched;

    localparam int CLK_PER_SEC = 1000;
    localparam int TOL         = 2;
    localparam int PULSE_LEN   = 4;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        pps;
    logic [9:0]  tm_tai;
    logic        link_up;
    logic        pps_ok;
    logic [31:0] pps_period;

    wr_pps_trigger_sched_if bus();

    wr_pps_trigger_sched #(
        .G_CLK_PER_SEC (CLK_PER_SEC),
        .G_TOL         (TOL),
        .G_PULSE_LEN   (PULSE_LEN)
    ) dut (
        .clk_sys_i    (clk_sys),
        .rst_i        (rst),
        .pps_i        (pps),
        .tm_tai_i     (tm_tai),
        .link_up_i    (link_up),
        .bus          (bus),
        .pps_ok_o     (pps_ok),
        .pps_period_o (pps_period)
    );

    always #5 clk_sys = ~clk_sys;

    int testsRun  = 0;
    int failCount = 0;
    int cycleNo   = 0;
    int nextEdge  = 0;
    int lastEdge  = 0;
    int period    = CLK_PER_SEC;
    int highLeft  = 0;
    int taiNow    = 0;
    bit ppsOn     = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: the PPS generator and the software inputs for cycle cycleNo.
    task automatic applyStimulus(input bit arm, input bit disarm, input logic [9:0] sec, input logic [31:0] cyc);
        @(negedge clk_sys);
        cycleNo++;
        if (ppsOn && cycleNo == nextEdge) begin
            pps      = 1'b1;
            taiNow   = (taiNow + 1) % 1024;
            tm_tai   = 10'(taiNow);
            highLeft = 2;
            lastEdge = cycleNo;
            nextEdge = cycleNo + period;
        end else if (highLeft > 0) begin
            pps = 1'b1;
            highLeft--;
        end else begin
            pps = 1'b0;
        end
        bus.arm_i        = arm;
        bus.disarm_i     = disarm;
        bus.target_sec_i = sec;
        bus.target_cyc_i = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 10'd0, 32'd0);
    endtask

    task automatic runTo(input int target);
        while (cycleNo < target) applyStimulus(1'b0, 1'b0, 10'd0, 32'd0);
    endtask

    task automatic setTai(input int v);
        taiNow = v;
        tm_tai = 10'(v);
    endtask

    task automatic alignSecond();
        if (nextEdge - cycleNo < 100) runTo(nextEdge + 10);
    endtask

    // Model: the target second arrives n whole periods after the next edge.
    task automatic runTrigger(input string tag, input logic [9:0] sec, input logic [31:0] cyc);
        int taiNext, n, expFirst, firstHigh, highs;
        alignSecond();
        taiNext  = (taiNow + 1) % 1024;
        n        = (int'(sec) - taiNext + 1024) % 1024;
        expFirst = nextEdge + n * period + int'(cyc) + 1;
        applyStimulus(1'b1, 1'b0, sec, cyc);
        idle(49);
        applyStimulus(1'b1, 1'b0, 10'($urandom), $urandom);
        firstHigh = -1;
        highs     = 0;
        while (!bus.done_o && cycleNo < expFirst + PULSE_LEN + 10) begin
            applyStimulus(1'b0, 1'b0, 10'd0, 32'd0);
            if (bus.trig_o) begin
                if (firstHigh < 0) firstHigh = cycleNo;
                highs++;
            end
        end
        checkOutput({tag, "_first_trig_cycle"}, 64'(firstHigh), 64'(expFirst));
        checkOutput({tag, "_pulse_len"}, 64'(highs), 64'(PULSE_LEN));
        checkOutput({tag, "_done_busy_err"}, {bus.done_o, bus.busy_o, bus.err_o}, 3'b100);
    endtask

    task automatic runLate(input string tag, input logic [9:0] sec);
        int e, errAt;
        alignSecond();
        e = nextEdge;
        applyStimulus(1'b1, 1'b0, sec, 32'($urandom_range(999, 0)));
        idle(1);
        checkOutput({tag, "_accepted"}, bus.busy_o, 1'b1);
        errAt = -1;
        while (cycleNo < e + 5) begin
            applyStimulus(1'b0, 1'b0, 10'd0, 32'd0);
            if (bus.err_o && errAt < 0) errAt = cycleNo;
        end
        checkOutput({tag, "_err_cycle"}, 64'(errAt), 64'(e + 1));
        checkOutput({tag, "_busy_code"}, {bus.busy_o, bus.err_code_o}, 3'b011);
    endtask

    initial begin
        int f, c, lastE;
        logic [9:0] s;

        rst = 1'b1;
        pps = 1'b0;
        link_up = 1'b1;
        setTai(2);
        bus.arm_i = 1'b0;
        bus.disarm_i = 1'b0;
        bus.target_sec_i = '0;
        bus.target_cyc_i = '0;
        idle(3);
        checkOutput("reset_outputs",
                    {bus.trig_o, bus.busy_o, bus.done_o, bus.err_o, bus.err_code_o, pps_ok, pps_period},
                    '0);
        rst = 1'b0;

        // Lock: first edge ignored, two good periods needed.
        ppsOn = 1'b1;
        nextEdge = cycleNo + 50;
        runTo(nextEdge + period + 1);
        checkOutput("ok_after_edge2", pps_ok, 1'b0);
        checkOutput("period_edge2", pps_period, 32'd1000);
        runTo(nextEdge);
        checkOutput("ok_in_edge3_cycle", pps_ok, 1'b0);
        idle(1);
        checkOutput("ok_after_edge3", pps_ok, 1'b1);

        // Period tolerance boundaries.
        nextEdge += 2;
        runTo(nextEdge + 1);
        checkOutput("period_1002", {pps_ok, pps_period}, {1'b1, 32'd1002});
        nextEdge -= 2;
        runTo(nextEdge + 1);
        checkOutput("period_998", {pps_ok, pps_period}, {1'b1, 32'd998});
        nextEdge += 5;
        runTo(nextEdge + 1);
        checkOutput("period_1005", {pps_ok, pps_period}, {1'b0, 32'd1005});
        runTo(nextEdge + 1);
        checkOutput("ok_after_one_good", pps_ok, 1'b0);
        runTo(nextEdge + 1);
        checkOutput("ok_relocked", pps_ok, 1'b1);

        setTai(5);
        runTrigger("sec7_cyc100", 10'd7, 32'd100);
        runTrigger("sec8_cyc0", 10'd8, 32'd0);

        applyStimulus(1'b1, 1'b0, 10'd9, 32'd1000);
        idle(1);
        checkOutput("badcyc_1000", {bus.busy_o, bus.err_o, bus.err_code_o}, 4'b0101);
        applyStimulus(1'b1, 1'b0, 10'd9, $urandom_range(32'hFFFF_FFFF, 32'd1001));
        idle(1);
        checkOutput("badcyc_rand", {bus.busy_o, bus.err_o, bus.err_code_o}, 4'b0101);
        applyStimulus(1'b1, 1'b0, 10'((taiNow + 2) % 1024), 32'd999);
        idle(1);
        checkOutput("cyc999_accepted", {bus.busy_o, bus.err_o}, 2'b10);
        applyStimulus(1'b0, 1'b1, 10'd0, 32'd0);
        idle(1);
        checkOutput("disarm_wait", {bus.busy_o, bus.err_o, bus.trig_o}, 3'b000);

        setTai(5);
        runLate("late_sec3", 10'd3);
        runLate("late_rand", 10'((taiNow + 1 - int'($urandom_range(511, 1)) + 1024) % 1024));

        for (int i = 0; i < 3; i++) begin
            runTrigger($sformatf("rand%0d", i),
                       10'((taiNow + 1 + int'($urandom_range(1, 0))) % 1024),
                       32'($urandom_range(999, 0)));
        end

        setTai(1000);
        runTrigger("wrap_sec2", 10'd2, 32'($urandom_range(999, 0)));

        link_up = 1'b0;
        idle(2);
        checkOutput("ok_link_down", pps_ok, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'((taiNow + 1) % 1024), 32'd10);
        idle(1);
        checkOutput("arm_unlocked", {bus.busy_o, bus.err_o, bus.err_code_o}, 4'b0110);
        link_up = 1'b1;
        runTo(nextEdge + 1);
        checkOutput("ok_link_restored", pps_ok, 1'b1);

        // Missing PPS while waiting for the target second.
        alignSecond();
        lastE = lastEdge;
        applyStimulus(1'b1, 1'b0, 10'((taiNow + 2) % 1024), 32'd50);
        ppsOn = 1'b0;
        runTo(lastE + 1003);
        checkOutput("ok_phase1003", {pps_ok, bus.busy_o}, 2'b11);
        idle(1);
        checkOutput("ok_phase1004", pps_ok, 1'b0);
        idle(1);
        checkOutput("lost_pps_err", {bus.busy_o, bus.err_o, bus.err_code_o}, 4'b0111);
        ppsOn = 1'b1;
        nextEdge = cycleNo + 20;
        runTo(nextEdge + 1);
        runTo(nextEdge + 1);
        checkOutput("relock_pending", pps_ok, 1'b0);
        runTo(nextEdge + 1);
        checkOutput("relock_done", pps_ok, 1'b1);

        // Disarm in the second cycle of the pulse.
        alignSecond();
        c = int'($urandom_range(900, 1));
        f = nextEdge + c + 1;
        applyStimulus(1'b1, 1'b0, 10'((taiNow + 1) % 1024), 32'(c));
        runTo(f);
        checkOutput("fire_cycle1", bus.trig_o, 1'b1);
        applyStimulus(1'b0, 1'b1, 10'd0, 32'd0);
        checkOutput("fire_cycle2", bus.trig_o, 1'b1);
        idle(1);
        checkOutput("disarm_fire", {bus.trig_o, bus.busy_o, bus.done_o, bus.err_o}, 4'b0000);
        idle(8);
        checkOutput("disarm_no_done", {bus.trig_o, bus.done_o}, 2'b00);

        alignSecond();
        applyStimulus(1'b1, 1'b1, 10'((taiNow + 1) % 1024), 32'd20);
        idle(1);
        checkOutput("arm_disarm_idle", {bus.busy_o, bus.err_o}, 2'b00);
        idle(4);
        checkOutput("arm_disarm_stays", bus.busy_o, 1'b0);

        // Asynchronous reset while in WAIT_CYC.
        alignSecond();
        s = 10'((taiNow + 1) % 1024);
        f = nextEdge;
        applyStimulus(1'b1, 1'b0, s, 32'd500);
        runTo(f + 100);
        checkOutput("wait_cyc_busy", {bus.busy_o, bus.trig_o}, 2'b10);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset",
                       {bus.trig_o, bus.busy_o, bus.done_o, bus.err_o, bus.err_code_o, pps_ok, pps_period},
                       '0);
        idle(2);
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
